// File: rtl/cpu_cmd_pkg.sv
// Command word layout, opcodes and dispatcher state encoding shared by the queue, decode and write stages.
package cpu_cmd_pkg;

    localparam int DATA_BITS = 14;
    localparam int ADDR_BITS = 12;
    localparam int OPC_BITS  = 4;
    localparam int CMD_W     = DATA_BITS + ADDR_BITS + OPC_BITS;

    localparam int OPC_LSB  = 0;
    localparam int ADDR_LSB = OPC_LSB + OPC_BITS;
    localparam int DATA_LSB = ADDR_LSB + ADDR_BITS;

    localparam logic [OPC_BITS-1:0] OPC_NOP   = 4'h0;
    localparam logic [OPC_BITS-1:0] OPC_STORE = 4'h1;
    localparam logic [OPC_BITS-1:0] OPC_LOAD  = 4'h2;
    localparam logic [OPC_BITS-1:0] OPC_ADDM  = 4'h3;
    localparam logic [OPC_BITS-1:0] OPC_CLR   = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4,
        S_MEM_RD = 3'd5,
        S_RMW_RD = 3'd6,
        S_RMW_WR = 3'd7
    } state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [ADDR_BITS-1:0] addr;
        logic [OPC_BITS-1:0]  opc;
    } cmd_t;

    function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] w);
        cmd_t c;
        c.opc  = w[OPC_LSB  +: OPC_BITS];
        c.addr = w[ADDR_LSB +: ADDR_BITS];
        c.data = w[DATA_LSB +: DATA_BITS];
        return c;
    endfunction

endpackage

// File: rtl/command_dispatch.sv
// Pops commands from the DECODE->WRITE queue and executes them as req/ack memory transactions.
// Latency: pop 1 cycle after cmd_pause falls, STORE 4+N cycles; backpressure: mem_req held until mem_ack or timeout.
module command_dispatch
    import cpu_cmd_pkg::*;
#(
    parameter int DATA_W      = 30,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DATA_W-1:0]    cmd_data,
    input  logic                 cmd_pause,
    output logic                 cmd_read,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 res_valid,
    output logic [DATA_BITS-1:0] res_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     cmd_count,
    output logic                 err_illegal,
    output logic                 err_timeout
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t               state, state_nxt;
    cmd_t                 cmd_q, cmd_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic                 req_nxt, we_nxt, res_vld_nxt, ill_nxt, tmo_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic [DATA_BITS-1:0] wdata_nxt, res_data_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ack_take, tmo_hit;

    assign cmd_read = (state == S_FETCH);
    assign busy     = (state != S_IDLE);
    assign ack_take = mem_req && mem_ack;
    assign tmo_hit  = mem_req && !mem_ack && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd_q;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        res_data_nxt = res_data;
        res_vld_nxt  = 1'b0;
        cnt_nxt      = cmd_count;
        ill_nxt      = 1'b0;
        tmo_nxt      = 1'b0;
        tmo_cnt_nxt  = mem_req ? tmo_cnt + 1'b1 : tmo_cnt;

        case (state)
            S_IDLE:  if (run && !cmd_pause) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                cmd_nxt   = unpack_cmd(cmd_data);
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_IDLE;
                case (cmd_q.opc)
                    OPC_NOP:   cnt_nxt = cmd_count + 1'b1;
                    OPC_STORE, OPC_CLR: begin
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b1;
                        addr_nxt  = cmd_q.addr;
                        wdata_nxt = (cmd_q.opc == OPC_CLR) ? '0 : cmd_q.data;
                        state_nxt = S_MEM_WR;
                    end
                    OPC_LOAD, OPC_ADDM: begin
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                        addr_nxt  = cmd_q.addr;
                        state_nxt = (cmd_q.opc == OPC_LOAD) ? S_MEM_RD : S_RMW_RD;
                    end
                    default:   ill_nxt = 1'b1;
                endcase
            end
            S_MEM_WR, S_MEM_RD, S_RMW_RD, S_RMW_WR: begin
                // Only the RMW write phase enters with mem_req low: that cycle is the bus gap.
                if (!mem_req) begin
                    req_nxt = 1'b1;
                end else if (tmo_hit) begin
                    req_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (ack_take) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                    if (state == S_RMW_RD) begin
                        we_nxt    = 1'b1;
                        wdata_nxt = mem_rdata + cmd_q.data;
                        state_nxt = S_RMW_WR;
                    end else begin
                        cnt_nxt = cmd_count + 1'b1;
                        if (state == S_MEM_RD) begin
                            res_data_nxt = mem_rdata;
                            res_vld_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (req_nxt && !mem_req) tmo_cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            tmo_cnt     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            cmd_count   <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            mem_req     <= req_nxt;
            mem_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            res_valid   <= res_vld_nxt;
            res_data    <= res_data_nxt;
            cmd_count   <= cnt_nxt;
            err_illegal <= ill_nxt;
            err_timeout <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_command_dispatch.sv
// Scoreboard bench for command_dispatch: queue and memory models drive the DUT, a monitor checks bus, results and error pulses.
module tb_command_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [29:0] cmd_data = '0;
    logic        cmd_pause = 1'b1;
    logic        cmd_read;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [13:0] mem_wdata;
    logic [13:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        res_valid;
    logic [13:0] res_data;
    logic        busy;
    logic [15:0] cmd_count;
    logic        err_illegal, err_timeout;

    command_dispatch dut (
        .clk(clk), .reset(reset), .run(run), .cmd_data(cmd_data), .cmd_pause(cmd_pause),
        .cmd_read(cmd_read), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .cmd_count(cmd_count),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [13:0] wdata;
    } bus_t;

    localparam int EVT_TMO = 1;
    localparam int EVT_ILL = 2;

    bus_t        exp_bus[$];
    logic [13:0] exp_res[$];
    int          exp_evt[$];
    logic [29:0] cmdq[$];

    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [13:0] rdata_val = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    // Queue: pop lands on the negedge of the FETCH cycle.
    always @(negedge clk) begin
        if (cmd_read && cmdq.size() > 0) cmd_data = cmdq.pop_front();
        cmd_pause = (cmdq.size() == 0);
    end

    // Memory: ack after ack_delay wait cycles, held until mem_req drops.
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            wait_cnt = 0;
            mem_ack  = 1'b0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
        end else begin
            mem_ack = 1'b0;
            wait_cnt++;
        end
        mem_rdata = rdata_val;
    end

    logic        prev_take = 0, prev_req = 0, prev_rd = 0, prev_res = 0, prev_ill = 0, prev_tmo = 0;
    logic [26:0] prev_bus = '0;

    always @(negedge clk) begin
        bus_t e;
        if (reset) begin
            prev_take = 0; prev_req = 0; prev_rd = 0; prev_res = 0; prev_ill = 0; prev_tmo = 0;
        end else begin
            if (prev_take) chk("req_drop_after_ack", mem_req, 0);
            if (mem_req && prev_req) chk("bus_stable", {mem_we, mem_addr, mem_wdata}, prev_bus);
            if (prev_rd)  chk("cmd_read_one_cycle", cmd_read, 0);
            if (prev_res) chk("res_valid_one_cycle", res_valid, 0);
            if (prev_ill) chk("err_illegal_one_cycle", err_illegal, 0);
            if (prev_tmo) chk("err_timeout_one_cycle", err_timeout, 0);
            if (mem_req && mem_ack) begin
                chk("bus_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    e = exp_bus.pop_front();
                    chk("bus_we", mem_we, e.we);
                    chk("bus_addr", mem_addr, e.addr);
                    if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
                end
            end
            if (res_valid) begin
                chk("res_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) chk("res_data", res_data, exp_res.pop_front());
            end
            if (err_timeout) begin
                chk("timeout_expected", exp_evt.size() != 0, 1);
                if (exp_evt.size() != 0) chk("timeout_event", EVT_TMO, exp_evt.pop_front());
            end
            if (err_illegal) begin
                chk("illegal_expected", exp_evt.size() != 0, 1);
                if (exp_evt.size() != 0) chk("illegal_event", EVT_ILL, exp_evt.pop_front());
            end
            prev_take = mem_req && mem_ack;
            prev_req  = mem_req;
            prev_bus  = {mem_we, mem_addr, mem_wdata};
            prev_rd   = cmd_read;
            prev_res  = res_valid;
            prev_ill  = err_illegal;
            prev_tmo  = err_timeout;
        end
    end

    task automatic push_cmd(input logic [29:0] w);
        @(posedge clk);
        #2;
        cmdq.push_back(w);
    endtask

    task automatic run_cmd(input logic [29:0] w, input int exp_busy, input string nm);
        int idx, n;
        push_cmd(w);
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                idx = i;
                break;
            end
        end
        chk({nm, "_started"}, idx >= 0, 1);
        if (idx >= 0) begin
            chk({nm, "_pop_delay"}, idx, 1);
            chk({nm, "_cmd_read"}, cmd_read, 1);
            n = 0;
            while (busy && n < 400) begin
                n++;
                @(negedge clk);
            end
            chk({nm, "_busy_cycles"}, n, exp_busy);
        end
    endtask

    initial begin
        logic anyhi;
        int   n;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {cmd_read, mem_req, mem_we, mem_addr, mem_wdata, res_valid, busy, err_illegal, err_timeout}, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_count", cmd_count, 0);
        reset = 1'b0;

        anyhi = 1'b0;
        repeat (20) begin
            @(negedge clk);
            anyhi = anyhi | cmd_read | busy | mem_req | res_valid | err_illegal | err_timeout;
        end
        chk("paused_idle", anyhi, 0);

        ack_delay = 2;
        exp_bus.push_back('{we: 1'b1, addr: 12'h123, wdata: 14'h1ABC});
        run_cmd({14'h1ABC, 12'h123, 4'h1}, 6, "store");
        chk("store_count", cmd_count, 1);

        ack_delay = 1;
        rdata_val = 14'h0155;
        exp_bus.push_back('{we: 1'b0, addr: 12'h010, wdata: 14'h0});
        exp_res.push_back(14'h0155);
        run_cmd({14'h0000, 12'h010, 4'h2}, 5, "load");
        @(negedge clk);
        chk("load_res_hold", res_data, 14'h0155);
        chk("load_count", cmd_count, 2);

        rdata_val = 14'h3FFE;
        exp_bus.push_back('{we: 1'b0, addr: 12'h007, wdata: 14'h0});
        exp_bus.push_back('{we: 1'b1, addr: 12'h007, wdata: 14'h0001});
        run_cmd({14'h0003, 12'h007, 4'h3}, 8, "addm");
        chk("addm_count", cmd_count, 3);

        ack_delay = 1000;
        exp_evt.push_back(EVT_TMO);
        run_cmd({14'h02AA, 12'h0F0, 4'h1}, 67, "timeout");
        @(negedge clk);
        chk("timeout_count", cmd_count, 3);

        exp_evt.push_back(EVT_ILL);
        run_cmd({14'h0001, 12'h001, 4'hF}, 3, "illegal");
        @(negedge clk);
        chk("illegal_count", cmd_count, 3);

        run_cmd(30'h0, 3, "nop");
        chk("nop_count", cmd_count, 4);

        ack_delay = 0;
        exp_bus.push_back('{we: 1'b1, addr: 12'h200, wdata: 14'h0000});
        run_cmd({14'h3FFF, 12'h200, 4'h4}, 4, "clr");
        chk("clr_count", cmd_count, 5);

        // Command left pending while run is low must not be fetched.
        run = 1'b0;
        push_cmd(30'h0);
        anyhi = 1'b0;
        repeat (6) begin
            @(negedge clk);
            anyhi = anyhi | busy | cmd_read;
        end
        chk("run_low_no_fetch", anyhi, 0);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || cmdq.size() != 0) && n < 50);
        chk("run_resume_count", cmd_count, 6);

        ack_delay = 1000;
        push_cmd({14'h1111, 12'h0AA, 4'h1});
        push_cmd({14'h0AAA, 12'h055, 4'h1});
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_store_req_seen", mem_req, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_req_async_drop", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cmd_count, 0);
        @(negedge clk);
        ack_delay = 0;
        exp_bus.push_back('{we: 1'b1, addr: 12'h055, wdata: 14'h0AAA});
        reset = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("after_rst_fetch", busy, 1);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("after_rst_count", cmd_count, 1);
        chk("after_rst_no_pulses", {err_timeout, err_illegal, res_valid}, 0);

        repeat (2) @(negedge clk);
        chk("bus_queue_drained", exp_bus.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        chk("evt_queue_drained", exp_evt.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
